// File: rtl/hd44780_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_pkg
//  Description : Shared definitions for the HD44780 4-bit write path: state
//                enumeration of the nybble sequencer and default timing
//                constants for a 48 MHz system clock.
//  Contents    : nyb_state_t        - sequencer state encoding
//                c_def_*_ticks      - default phase lengths in clock cycles
//                max_int()          - helper for counter width derivation
//  Revision    : 1.0 - initial release
// ============================================================================
package hd44780_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_WAIT  = 3'd4
   } nyb_state_t;

   // 48 MHz defaults: tAS, PWEH, hold, 40 us command time, 1.64 ms clear/home
   localparam int c_def_setup_ticks  = 3;
   localparam int c_def_epulse_ticks = 12;
   localparam int c_def_hold_ticks   = 12;
   localparam int c_def_short_ticks  = 1920;
   localparam int c_def_long_ticks   = 78720;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hd44780_nybbler_if.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_nybbler_if
//  Description : Request/ready handshake between a transfer source and the
//                HD44780 nybble sequencer.
//  Signals     : i_valid  - request one transfer
//                o_ready  - sequencer idle, accepts when i_valid is high
//                i_byte   - byte to send, high nybble first
//                i_rs     - register select (0 command, 1 data)
//                i_single - send only the high nybble
//                i_long   - use the long post-transfer busy time
//  Modports    : master (request source), slave (sequencer)
//  Revision    : 1.0 - initial release
// ============================================================================
interface hd44780_nybbler_if;

   logic       i_valid;
   logic       o_ready;
   logic [7:0] i_byte;
   logic       i_rs;
   logic       i_single;
   logic       i_long;

   modport master (
      output i_valid, i_byte, i_rs, i_single, i_long,
      input  o_ready
   );

   modport slave (
      input  i_valid, i_byte, i_rs, i_single, i_long,
      output o_ready
   );

endinterface
`default_nettype wire

// File: rtl/hd44780_delay_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_delay_ctr
//  Description : Loadable down-counter timing every sequencer phase. A load
//                takes priority; otherwise the count decrements and parks at
//                zero. o_done flags the last cycle of a phase (count == 1).
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                i_load    - load i_value on this edge
//                i_value   - phase length in cycles
//                o_done    - current cycle is the final one of the phase
//  Revision    : 1.0 - initial release
// ============================================================================
module hd44780_delay_ctr #(
   parameter int WIDTH = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_load,
   input  wire logic [WIDTH-1:0] i_value,
   output logic                  o_done
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_done = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/hd44780_nybbler.sv
`default_nettype none
// ============================================================================
//  Module      : hd44780_nybbler
//  Description : Sends one byte (or only its high nybble) to an HD44780 in
//                4-bit mode: SETUP / E PULSE / HOLD per nybble, then a busy
//                WAIT before accepting the next request.
//  Ports       : CLK_I, RST_I - system clock, synchronous active-high reset
//                bus          - request handshake (slave side)
//                lcd_rs       - LCD register select
//                lcd_e        - LCD enable strobe (flip-flop driven)
//                lcd_data     - LCD DB7..DB4
//  Revision    : 1.0 - initial release
// ============================================================================
module hd44780_nybbler
   import hd44780_pkg::*;
#(
   parameter int SETUP_TICKS      = c_def_setup_ticks,
   parameter int EPULSE_TICKS     = c_def_epulse_ticks,
   parameter int HOLD_TICKS       = c_def_hold_ticks,
   parameter int SHORT_WAIT_TICKS = c_def_short_ticks,
   parameter int LONG_WAIT_TICKS  = c_def_long_ticks
) (
   input  wire logic         CLK_I,
   input  wire logic         RST_I,
   hd44780_nybbler_if.slave  bus,
   output logic              lcd_rs,
   output logic              lcd_e,
   output logic [3:0]        lcd_data
);

   localparam int c_max_ticks = max_int(max_int(max_int(SETUP_TICKS, EPULSE_TICKS),
                                                max_int(HOLD_TICKS, SHORT_WAIT_TICKS)),
                                        LONG_WAIT_TICKS);
   localparam int c_cnt_w = $clog2(c_max_ticks) + 1;

   localparam logic [c_cnt_w-1:0] c_ld_setup = c_cnt_w'(SETUP_TICKS);
   localparam logic [c_cnt_w-1:0] c_ld_pulse = c_cnt_w'(EPULSE_TICKS);
   localparam logic [c_cnt_w-1:0] c_ld_hold  = c_cnt_w'(HOLD_TICKS);
   localparam logic [c_cnt_w-1:0] c_ld_short = c_cnt_w'(SHORT_WAIT_TICKS);
   localparam logic [c_cnt_w-1:0] c_ld_long  = c_cnt_w'(LONG_WAIT_TICKS);

   nyb_state_t         r_state;
   nyb_state_t         w_state_next;
   logic               r_lo_pending;
   logic               w_lo_next;
   logic [3:0]         r_byte_lo;
   logic               r_long;
   logic               r_e;
   logic               r_rs;
   logic [3:0]         r_data;
   logic               w_e_next;
   logic               w_rs_next;
   logic [3:0]         w_data_next;
   logic               w_load;
   logic [c_cnt_w-1:0] w_load_val;
   logic               w_done;
   logic               w_accept;

   assign w_accept    = bus.i_valid && (r_state == ST_IDLE);
   assign bus.o_ready = (r_state == ST_IDLE);

   hd44780_delay_ctr #(
      .WIDTH (c_cnt_w)
   ) u_delay_ctr (
      .clk     (CLK_I),
      .rst     (RST_I),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_done  (w_done)
   );

   // State register plus the registered pin drivers and request latches
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         r_state      <= ST_IDLE;
         r_lo_pending <= 1'b0;
         r_byte_lo    <= 4'h0;
         r_long       <= 1'b0;
         r_e          <= 1'b0;
         r_rs         <= 1'b0;
         r_data       <= 4'h0;
      end else begin
         r_state      <= w_state_next;
         r_lo_pending <= w_lo_next;
         r_e          <= w_e_next;
         r_rs         <= w_rs_next;
         r_data       <= w_data_next;
         if (w_accept) begin
            r_byte_lo <= bus.i_byte[3:0];
            r_long    <= bus.i_long;
         end
      end
   end

   // Next-state decode: every timed phase ends on the counter's done cycle
   always_comb begin
      w_state_next = r_state;
      w_lo_next    = r_lo_pending;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = ST_SETUP;
               w_lo_next    = ~bus.i_single;
            end
         end
         ST_SETUP: begin
            if (w_done) w_state_next = ST_PULSE;
         end
         ST_PULSE: begin
            if (w_done) w_state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_done) begin
               if (r_lo_pending) begin
                  w_state_next = ST_SETUP;
                  w_lo_next    = 1'b0;
               end else begin
                  w_state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (w_done) w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
            w_lo_next    = 1'b0;
         end
      endcase
   end

   // Output decode: values for the pin flops and the counter load on entry
   // to each phase. E is taken from the next state so the pin itself is a
   // plain register output.
   always_comb begin
      w_e_next    = (w_state_next == ST_PULSE);
      w_rs_next   = r_rs;
      w_data_next = r_data;
      if (w_state_next == ST_IDLE) begin
         w_rs_next   = 1'b0;
         w_data_next = 4'h0;
      end else if (w_accept) begin
         w_rs_next   = bus.i_rs;
         w_data_next = bus.i_byte[7:4];
      end else if ((r_state == ST_HOLD) && (w_state_next == ST_SETUP)) begin
         w_data_next = r_byte_lo;
      end

      w_load = (w_state_next != r_state);
      case (w_state_next)
         ST_SETUP: w_load_val = c_ld_setup;
         ST_PULSE: w_load_val = c_ld_pulse;
         ST_HOLD:  w_load_val = c_ld_hold;
         ST_WAIT:  w_load_val = r_long ? c_ld_long : c_ld_short;
         default:  w_load_val = '0;
      endcase
   end

   assign lcd_e    = r_e;
   assign lcd_rs   = r_rs;
   assign lcd_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_hd44780_nybbler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hd44780_nybbler
//  Description : Self-checking bench for hd44780_nybbler. Expected pin
//                traces are computed from the transfer timing rules: each
//                nybble occupies S+P+H cycles with E high in positions
//                [S, S+P), followed by a W-cycle wait and one idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hd44780_nybbler;

   localparam int c_s  = 2;
   localparam int c_p  = 3;
   localparam int c_h  = 2;
   localparam int c_sw = 5;
   localparam int c_lw = 9;
   localparam logic [6:0] c_idle = 7'b1000000;

   logic       CLK_I = 1'b0;
   logic       RST_I = 1'b1;
   logic       lcd_rs;
   logic       lcd_e;
   logic [3:0] lcd_data;
   logic [6:0] w_obs;

   int n_pass  = 0;
   int n_total = 0;

   hd44780_nybbler_if bus ();

   hd44780_nybbler #(
      .SETUP_TICKS      (c_s),
      .EPULSE_TICKS     (c_p),
      .HOLD_TICKS       (c_h),
      .SHORT_WAIT_TICKS (c_sw),
      .LONG_WAIT_TICKS  (c_lw)
   ) dut (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .bus      (bus),
      .lcd_rs   (lcd_rs),
      .lcd_e    (lcd_e),
      .lcd_data (lcd_data)
   );

   always #5 CLK_I = ~CLK_I;

   assign w_obs = {bus.o_ready, lcd_e, lcd_rs, lcd_data};

   // Busy cycles after the accept edge
   function automatic int busy_len(input logic single, input logic lng);
      return (single ? 1 : 2) * (c_s + c_p + c_h) + (lng ? c_lw : c_sw);
   endfunction

   // Expected {ready, e, rs, data} in cycle T0+k of a transfer accepted at T0
   function automatic logic [6:0] model(input logic [7:0] b, input logic rs,
                                        input logic single, input logic lng,
                                        input int k);
      int n, per, nib, pos;
      logic e;
      logic [3:0] d;
      n   = single ? 1 : 2;
      per = c_s + c_p + c_h;
      if (k < 1 || k > busy_len(single, lng)) return c_idle;
      if (k <= n * per) begin
         nib = (k - 1) / per;
         pos = (k - 1) % per;
         e   = (pos >= c_s) && (pos < c_s + c_p);
      end else begin
         nib = n - 1;
         e   = 1'b0;
      end
      d = (nib == 0) ? b[7:4] : b[3:0];
      return {1'b0, e, rs, d};
   endfunction

   // Present a request at the negedge; returns at the sample point of T0+1
   task automatic start(input logic [7:0] b, input logic rs,
                        input logic single, input logic lng);
      @(negedge CLK_I);
      bus.i_byte   = b;
      bus.i_rs     = rs;
      bus.i_single = single;
      bus.i_long   = lng;
      bus.i_valid  = 1'b1;
      @(posedge CLK_I);
      #1;
   endtask

   // Advance one cycle with i_valid low, optionally disturbing the inputs
   task automatic tick(input bit scramble);
      @(negedge CLK_I);
      bus.i_valid = 1'b0;
      if (scramble) begin
         bus.i_byte   = 8'($urandom);
         bus.i_rs     = 1'($urandom);
         bus.i_single = 1'($urandom);
         bus.i_long   = 1'($urandom);
      end
      @(posedge CLK_I);
      #1;
   endtask

   task automatic test_reset();
      RST_I       = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_byte  = 8'hFF;
      bus.i_rs    = 1'b1;
      bus.i_single = 1'b0;
      bus.i_long   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK_I);
         #1;
         n_total++;
         if (w_obs !== c_idle) $display("FAIL reset_idle cyc=%0d got %b want %b", i, w_obs, c_idle);
         else n_pass++;
      end
      @(negedge CLK_I);
      RST_I       = 1'b0;
      bus.i_valid = 1'b0;
      @(posedge CLK_I);
      #1;
      n_total++;
      if (w_obs !== c_idle) $display("FAIL post_reset_idle got %b want %b", w_obs, c_idle);
      else n_pass++;
   endtask

   task automatic test_basic();
      int last;
      last = busy_len(1'b0, 1'b0) + 1;
      start(8'h3C, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= last; k++) begin
         n_total++;
         if (w_obs !== model(8'h3C, 1'b1, 1'b0, 1'b0, k))
            $display("FAIL basic k=%0d got %b want %b", k, w_obs, model(8'h3C, 1'b1, 1'b0, 1'b0, k));
         else n_pass++;
         if (k < last) tick(1'b0);
      end
   endtask

   task automatic test_single();
      int last, pulses;
      logic prev_e;
      last   = busy_len(1'b1, 1'b0) + 1;
      pulses = 0;
      prev_e = 1'b0;
      start(8'h30, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= last; k++) begin
         n_total++;
         if (w_obs !== model(8'h30, 1'b0, 1'b1, 1'b0, k))
            $display("FAIL single k=%0d got %b want %b", k, w_obs, model(8'h30, 1'b0, 1'b1, 1'b0, k));
         else n_pass++;
         if (lcd_e === 1'b1 && prev_e !== 1'b1) pulses++;
         prev_e = lcd_e;
         if (k < last) tick(1'b0);
      end
      n_total++;
      if (pulses !== 1) $display("FAIL single_pulse_count got %0d want 1", pulses);
      else n_pass++;
   endtask

   task automatic test_long();
      int last;
      last = busy_len(1'b0, 1'b1) + 1;
      start(8'h01, 1'b0, 1'b0, 1'b1);
      for (int k = 1; k <= last; k++) begin
         n_total++;
         if (w_obs !== model(8'h01, 1'b0, 1'b0, 1'b1, k))
            $display("FAIL long k=%0d got %b want %b", k, w_obs, model(8'h01, 1'b0, 1'b0, 1'b1, k));
         else n_pass++;
         if (k < last) tick(1'b1);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bq[3];
      logic       rq[3];
      int         last;
      last = busy_len(1'b0, 1'b0) + 1;
      for (int i = 0; i < 3; i++) begin
         bq[i] = 8'($urandom);
         rq[i] = 1'($urandom);
      end
      start(bq[0], rq[0], 1'b0, 1'b0);
      for (int t = 0; t < 3; t++) begin
         for (int k = 1; k <= last; k++) begin
            n_total++;
            if (w_obs !== model(bq[t], rq[t], 1'b0, 1'b0, k))
               $display("FAIL b2b t=%0d k=%0d got %b want %b", t, k, w_obs, model(bq[t], rq[t], 1'b0, 1'b0, k));
            else n_pass++;
            if (!(t == 2 && k == last)) begin
               @(negedge CLK_I);
               if (k == 1 && t < 2) begin
                  bus.i_byte = bq[t+1];
                  bus.i_rs   = rq[t+1];
               end
               if (k == 1 && t == 2) bus.i_valid = 1'b0;
               @(posedge CLK_I);
               #1;
            end
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [7:0] b;
      logic       rs;
      int         last;
      start(8'h3C, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         n_total++;
         if (w_obs !== model(8'h3C, 1'b1, 1'b0, 1'b0, k))
            $display("FAIL rst_pre k=%0d got %b want %b", k, w_obs, model(8'h3C, 1'b1, 1'b0, 1'b0, k));
         else n_pass++;
         if (k < 4) tick(1'b0);
      end
      @(negedge CLK_I);
      RST_I = 1'b1;
      @(posedge CLK_I);
      #1;
      n_total++;
      if (w_obs !== c_idle) $display("FAIL rst_mid_pulse got %b want %b", w_obs, c_idle);
      else n_pass++;
      @(negedge CLK_I);
      RST_I = 1'b0;
      b     = 8'($urandom);
      rs    = 1'($urandom);
      last  = busy_len(1'b0, 1'b0) + 1;
      start(b, rs, 1'b0, 1'b0);
      for (int k = 1; k <= last; k++) begin
         n_total++;
         if (w_obs !== model(b, rs, 1'b0, 1'b0, k))
            $display("FAIL rst_after k=%0d got %b want %b", k, w_obs, model(b, rs, 1'b0, 1'b0, k));
         else n_pass++;
         if (k < last) tick(1'b0);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       rs, single, lng;
      int         last;
      for (int i = 0; i < 8; i++) begin
         b      = 8'($urandom);
         rs     = 1'($urandom);
         single = 1'($urandom);
         lng    = 1'($urandom);
         last   = busy_len(single, lng) + 1;
         start(b, rs, single, lng);
         for (int k = 1; k <= last; k++) begin
            n_total++;
            if (w_obs !== model(b, rs, single, lng, k))
               $display("FAIL random i=%0d k=%0d got %b want %b", i, k, w_obs, model(b, rs, single, lng, k));
            else n_pass++;
            if (k < last) tick(1'b1);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got timeout want completion");
      $fatal(1);
   end

   initial begin
      bus.i_valid  = 1'b0;
      bus.i_byte   = 8'h00;
      bus.i_rs     = 1'b0;
      bus.i_single = 1'b0;
      bus.i_long   = 1'b0;
      test_reset();
      test_basic();
      test_single();
      test_long();
      test_back_to_back();
      test_reset_mid_pulse();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
